// File: rtl/hist_pkg.sv
// Shared histogram definitions: default widths, readout FSM states and the beat
// record passed between the accumulator, the readout and downstream consumers.
package hist_pkg;
    localparam int HIST_BIN_W    = 10;
    localparam int HIST_CNT_W    = 32;
    localparam int HIST_CUM_W    = HIST_CNT_W + HIST_BIN_W;
    localparam int HIST_NUM_BINS = 1 << HIST_BIN_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } hist_state_t;

    typedef struct packed {
        logic [HIST_BIN_W-1:0] index;
        logic [HIST_CNT_W-1:0] count;
        logic [HIST_CUM_W-1:0] cum;
        logic                  last;
    } hist_beat_t;
endpackage

// File: rtl/hist_skid_buf.sv
// Two-entry fall-through beat buffer: an arriving beat is presented the same
// cycle when empty, and parked in the head/tail registers while stalled.
module hist_skid_buf #(
    parameter type T = logic [7:0]
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  T           in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output T           out_data,
    output logic [1:0] occ
);
    T     head, tail;
    logic head_v, tail_v;
    logic pop;

    assign out_valid = head_v | in_valid;
    assign out_data  = (!head_v && in_valid) ? in_data : head;
    assign occ       = {1'b0, head_v} + {1'b0, tail_v};
    assign pop       = out_valid && out_ready;

    // Upstream credit guarantees an arrival never meets a full buffer without a pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            head   <= '0;
            tail   <= '0;
            head_v <= 1'b0;
            tail_v <= 1'b0;
        end else if (head_v) begin
            if (pop) begin
                if (tail_v) begin
                    head   <= tail;
                    tail_v <= in_valid;
                    if (in_valid) tail <= in_data;
                end else begin
                    head_v <= in_valid;
                    if (in_valid) head <= in_data;
                end
            end else if (in_valid) begin
                tail   <= in_data;
                tail_v <= 1'b1;
            end
        end else if (in_valid && !out_ready) begin
            head   <= in_data;
            head_v <= 1'b1;
        end
    end
endmodule

// File: rtl/histogram_readout.sv
// Sequential histogram bin reader streaming index/count/cumulative beats.
// Define HIST_CLEAR_ON_READ_EN to zero each bin in the cycle its data returns.
module histogram_readout
    import hist_pkg::*;
#(
    parameter int BIN_W = HIST_BIN_W,
    parameter int CNT_W = HIST_CNT_W,
    parameter int CUM_W = CNT_W + BIN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CUM_W-1:0] total,
    output logic             rd_en,
    output logic [BIN_W-1:0] rd_addr,
    input  logic [CNT_W-1:0] rd_data,
    output logic             wr_en,
    output logic [BIN_W-1:0] wr_addr,
    output logic [CNT_W-1:0] wr_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BIN_W-1:0] out_index,
    output logic [CNT_W-1:0] out_count,
    output logic [CUM_W-1:0] out_cum,
    output logic             out_last
);
    localparam int               NUM_BINS = 1 << BIN_W;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

    typedef struct packed {
        logic [BIN_W-1:0] index;
        logic [CNT_W-1:0] count;
        logic [CUM_W-1:0] cum;
        logic             last;
    } beat_t;

    hist_state_t      state;
    logic             rvalid;
    logic [BIN_W-1:0] ret_idx;
    logic [CUM_W-1:0] cum, cum_next;
    logic [1:0]       occ;
    logic             accept;
    beat_t            in_beat, out_beat;

    assign cum_next = cum + CUM_W'(rd_data);

    always_comb begin
        in_beat       = '0;
        in_beat.index = ret_idx;
        in_beat.count = rd_data;
        in_beat.cum   = cum_next;
        in_beat.last  = (ret_idx == LAST_BIN);
    end

    hist_skid_buf #(.T(beat_t)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .in_valid (rvalid),
        .in_data  (in_beat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_beat),
        .occ      (occ)
    );

    assign out_index = out_beat.index;
    assign out_count = out_beat.count;
    assign out_cum   = out_beat.cum;
    assign out_last  = out_beat.last;
    assign accept    = out_valid && out_ready;

    // Buffered beats plus the returning read, less this cycle's pop, must leave a free slot.
    assign rd_en = (state == ST_SCAN) &&
                   (({1'b0, occ} + {2'b0, rvalid}) < (3'd2 + {2'b0, accept}));

`ifdef HIST_CLEAR_ON_READ_EN
    assign wr_en   = rvalid;
    assign wr_addr = ret_idx;
`else
    assign wr_en   = 1'b0;
    assign wr_addr = '0;
`endif
    assign wr_data = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_addr <= '0;
            rvalid  <= 1'b0;
            ret_idx <= '0;
            cum     <= '0;
            total   <= '0;
        end else begin
            rvalid <= rd_en;
            done   <= 1'b0;
            if (rd_en) ret_idx <= rd_addr;
            if (rvalid) cum <= cum_next;
            case (state)
                ST_IDLE: if (start) begin
                    state   <= ST_SCAN;
                    busy    <= 1'b1;
                    rd_addr <= '0;
                    cum     <= '0;
                end
                ST_SCAN: if (rd_en) begin
                    if (rd_addr == LAST_BIN) state <= ST_DRAIN;
                    else rd_addr <= rd_addr + 1'b1;
                end
                ST_DRAIN: if (accept && out_beat.last) begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    total <= out_beat.cum;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
